// File: rtl/pbus_master_if.sv
// Peripheral-bus master interface bundle.
// Groups the CPU request/response handshake and the shared peripheral bus.
//   master modport : pbus_master view (drives cpu_ack/cpu_rdata/cpu_rvalid/busy
//                    and all sys_* lines except sys_r_line).
//   slave modport  : CPU + peripheral view (drives requests and sys_r_line).
interface pbus_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        busy;
  logic        sys_w;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_w_line;
  logic        sys_r;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_r_line;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sys_r_line,
    output cpu_ack, cpu_rdata, cpu_rvalid, busy,
           sys_w, sys_w_addr, sys_w_line, sys_r, sys_r_addr
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, sys_r_line,
    input  cpu_ack, cpu_rdata, cpu_rvalid, busy,
           sys_w, sys_w_addr, sys_w_line, sys_r, sys_r_addr
  );
endinterface

// File: rtl/pbus_master.sv
// Peripheral-bus initiator.
// Converts single-word CPU loads/stores into peripheral bus cycles. Stores are
// posted through a WQ_DEPTH-entry queue and drained one per cycle; loads wait
// until the queue is empty and complete in order behind all stores.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - pbus_master_if.master: cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//          cpu_ack (combinational), cpu_rdata/cpu_rvalid, busy,
//          sys_w/sys_w_addr/sys_w_line, sys_r/sys_r_addr out, sys_r_line in.
module pbus_master #(
  parameter int unsigned WQ_DEPTH = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  pbus_master_if.master     bus
);

  localparam int unsigned AW = $clog2(WQ_DEPTH);
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, R_ISSUE, R_WAIT, R_DONE} state_t;

  state_t        state;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [31:0]   q_addr [WQ_DEPTH];
  logic [31:0]   q_data [WQ_DEPTH];
  logic [CW-1:0] cnt;

  logic empty;
  logic full;
  logic rd_pending;
  logic st_ack;
  logic ld_ack;
  logic pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty      = (wptr == rptr);
    full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    rd_pending = (state != IDLE);
    st_ack     = bus.cpu_req & bus.cpu_we & ~full & ~rd_pending;
    ld_ack     = bus.cpu_req & ~bus.cpu_we & (state == IDLE) & empty & ~bus.sys_w;
    // A load is only accepted with the queue empty, so pop and read issue
    // can never coincide and sys_w/sys_r stay mutually exclusive.
    pop        = ~empty & (state == IDLE);
    bus.cpu_ack = st_ack | ld_ack;
    bus.busy    = ~empty | bus.sys_w | rd_pending;
  end

  // Queue storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (st_ack) begin
      q_addr[wptr[AW-1:0]] <= bus.cpu_addr;
      q_data[wptr[AW-1:0]] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      wptr           <= '0;
      rptr           <= '0;
      cnt            <= '0;
      bus.sys_w      <= 1'b0;
      bus.sys_w_addr <= '0;
      bus.sys_w_line <= '0;
      bus.sys_r      <= 1'b0;
      bus.sys_r_addr <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
    end else begin
      if (st_ack) begin
        wptr <= wptr + (AW+1)'(1);
      end

      bus.sys_w <= 1'b0;
      if (pop) begin
        rptr           <= rptr + (AW+1)'(1);
        bus.sys_w      <= 1'b1;
        bus.sys_w_addr <= q_addr[rptr[AW-1:0]];
        bus.sys_w_line <= q_data[rptr[AW-1:0]];
      end

      case (state)
        IDLE: begin
          if (ld_ack) begin
            state          <= R_ISSUE;
            bus.sys_r      <= 1'b1;
            bus.sys_r_addr <= bus.cpu_addr;
          end
        end
        R_ISSUE: begin
          bus.sys_r <= 1'b0;
          cnt       <= CW'(RD_LAT - 1);
          state     <= R_WAIT;
        end
        R_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.cpu_rdata  <= bus.sys_r_line;
            bus.cpu_rvalid <= 1'b1;
            state          <= R_DONE;
          end
        end
        R_DONE: begin
          bus.cpu_rvalid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_master.sv
// Self-checking bench for pbus_master.
// dut_a runs with RD_LAT=1, dut_b with RD_LAT=3; each has a small GPIO
// peripheral (0x300 = input pins, 0x301 = output register).
module tb_pbus_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pbus_master_if ifa ();
  pbus_master_if ifb ();

  pbus_master #(.WQ_DEPTH(4), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pbus_master #(.WQ_DEPTH(4), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  localparam logic [31:0] PINS = 32'hA5A5A5A5;

  // GPIO peripherals: registered read data, driven the cycle after sys_r.
  logic [31:0] gpio_a, gpio_b, line_a, line_b;

  function automatic logic [31:0] gpio_rd(input logic [31:0] a, input logic [31:0] r);
    if (a == 32'h300) return PINS;
    if (a == 32'h301) return r;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      gpio_a <= '0; gpio_b <= '0; line_a <= '0; line_b <= '0;
    end else begin
      if (ifa.sys_w && ifa.sys_w_addr == 32'h301) gpio_a <= ifa.sys_w_line;
      if (ifb.sys_w && ifb.sys_w_addr == 32'h301) gpio_b <= ifb.sys_w_line;
      if (ifa.sys_r) line_a <= gpio_rd(ifa.sys_r_addr, gpio_a);
      if (ifb.sys_r) line_b <= gpio_rd(ifb.sys_r_addr, gpio_b);
    end
  end

  assign ifa.sys_r_line = line_a;
  assign ifb.sys_r_line = line_b;

  // Scoreboard
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq_a[$];
  logic [31:0] rq_b[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_w = -10;
  int streak = 0;
  int rwid_a = 0;
  int rwid_b = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: bus writes, read strobe width and load returns.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (ifa.sys_w) begin
        if (wq.size() == 0) begin
          chk("a_sys_w_spurious", 64'(wq.size()), 1);
        end else begin
          e = wq.pop_front();
          chk("a_w_addr", ifa.sys_w_addr, e.a);
          chk("a_w_line", ifa.sys_w_line, e.d);
        end
        chk("a_w_r_excl", ifa.sys_r, 0);
        if (cyc == last_w + 1) streak++;
        else streak = 1;
        last_w = cyc;
      end
      if (ifb.sys_w) chk("b_sys_w_spurious", ifb.sys_w, 0);

      if (ifa.sys_r) rwid_a++;
      else if (rwid_a != 0) begin chk("a_sys_r_width", rwid_a, 1); rwid_a = 0; end
      if (ifb.sys_r) rwid_b++;
      else if (rwid_b != 0) begin chk("b_sys_r_width", rwid_b, 1); rwid_b = 0; end

      if (ifa.cpu_rvalid) begin
        if (rq_a.size() == 0) chk("a_rvalid_spurious", 64'(rq_a.size()), 1);
        else chk("a_rdata", ifa.cpu_rdata, rq_a.pop_front());
      end
      if (ifb.cpu_rvalid) begin
        if (rq_b.size() == 0) chk("b_rvalid_spurious", 64'(rq_b.size()), 1);
        else chk("b_rdata", ifb.cpu_rdata, rq_b.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, output int waits);
    ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b1; ifa.cpu_addr = a; ifa.cpu_wdata = d;
    waits = 0;
    @(negedge clk);
    while (!ifa.cpu_ack && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ifa.cpu_ack) chk("a_st_ack_timeout", ifa.cpu_ack, 1);
    else wq.push_back('{a: a, d: d});
    @(posedge clk); #1;
    ifa.cpu_req = 1'b0;
  endtask

  // Load; exp_lat = clock edges from the ack edge to the rvalid edge.
  task automatic load(input bit on_b, input logic [31:0] a, input logic [31:0] exp,
                      input int exp_lat);
    int w;
    int n;
    logic ack;
    logic rv;
    if (on_b) begin ifb.cpu_req = 1'b1; ifb.cpu_we = 1'b0; ifb.cpu_addr = a; end
    else      begin ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b0; ifa.cpu_addr = a; end
    w = 0;
    @(negedge clk);
    ack = on_b ? ifb.cpu_ack : ifa.cpu_ack;
    while (!ack && w < 50) begin
      @(negedge clk);
      w++;
      ack = on_b ? ifb.cpu_ack : ifa.cpu_ack;
    end
    if (!ack) begin
      chk(on_b ? "b_ld_ack_timeout" : "a_ld_ack_timeout", ack, 1);
    end else begin
      if (!on_b) chk("a_ld_ack_during_sys_w", ifa.sys_w, 0);
      if (on_b) rq_b.push_back(exp);
      else      rq_a.push_back(exp);
    end
    @(posedge clk); #1;
    if (on_b) ifb.cpu_req = 1'b0;
    else      ifa.cpu_req = 1'b0;
    if (ack) begin
      n = 0;
      rv = 1'b0;
      while (!rv && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        rv = on_b ? ifb.cpu_rvalid : ifa.cpu_rvalid;
      end
      if (!rv) chk(on_b ? "b_rvalid_timeout" : "a_rvalid_timeout", rv, 1);
      else     chk(on_b ? "b_rd_latency" : "a_rd_latency", n, exp_lat);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero(input string pfx, input bit on_b);
    if (on_b) begin
      chk({pfx, "_b_outs"}, {ifb.sys_w, ifb.sys_r, ifb.cpu_rvalid, ifb.busy, ifb.cpu_ack}, 0);
      chk({pfx, "_b_rdata"}, ifb.cpu_rdata, 0);
      chk({pfx, "_b_sys_r_addr"}, ifb.sys_r_addr, 0);
      chk({pfx, "_b_sys_w_addr"}, ifb.sys_w_addr, 0);
    end else begin
      chk({pfx, "_a_outs"}, {ifa.sys_w, ifa.sys_r, ifa.cpu_rvalid, ifa.busy, ifa.cpu_ack}, 0);
      chk({pfx, "_a_sys_w_addr"}, ifa.sys_w_addr, 0);
      chk({pfx, "_a_sys_w_line"}, ifa.sys_w_line, 0);
      chk({pfx, "_a_rdata"}, ifa.cpu_rdata, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit without finishing", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifb.cpu_req = 1'b0; ifb.cpu_we = 1'b0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("rst", 1'b0);
    chk_zero("rst", 1'b1);
    @(posedge clk); #1;

    // Single store: acked same cycle, bus write one cycle after push edge.
    store(32'h100, 32'hDEADBEEF, w);
    chk("t1_ack_same_cycle", w, 0);
    @(negedge clk);
    chk("t1_no_w_at_push", ifa.sys_w, 0);
    @(negedge clk);
    chk("t1_w_strobe", ifa.sys_w, 1);
    @(negedge clk);
    chk("t1_w_single", ifa.sys_w, 0);
    chk("t1_busy_clear", ifa.busy, 0);
    @(posedge clk); #1;

    // Six back-to-back stores: in order, consecutive strobes.
    for (int i = 0; i < 6; i++) store(32'h200 + 32'(i), 32'h1000 + 32'(i), w);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_w_streak", streak, 6);
    chk("t2_wq_drained", 64'(wq.size()), 0);

    // Store then load to the same GPIO register.
    store(32'h301, 32'h0000FFFF, w);
    load(1'b0, 32'h301, 32'h0000FFFF, 2);

    // Load input pins with both read latencies.
    load(1'b0, 32'h300, PINS, 2);
    load(1'b1, 32'h300, PINS, 4);

    // Store presented while a read is pending: first IDLE cycle acks it.
    ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b0; ifa.cpu_addr = 32'h300;
    @(negedge clk);
    chk("t6_ld_ack", ifa.cpu_ack, 1);
    if (ifa.cpu_ack) rq_a.push_back(PINS);
    @(posedge clk); #1;
    ifa.cpu_we = 1'b1; ifa.cpu_addr = 32'h500; ifa.cpu_wdata = 32'h55AA;
    n = 0;
    @(negedge clk);
    while (!ifa.cpu_ack && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("t6_st_ack_edges", n, 3);
    if (ifa.cpu_ack) wq.push_back('{a: 32'h500, d: 32'h55AA});
    @(posedge clk); #1;
    ifa.cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-read on dut_b with a store still queued on dut_a.
    ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b1; ifa.cpu_addr = 32'h400; ifa.cpu_wdata = 32'h1;
    ifb.cpu_req = 1'b1; ifb.cpu_we = 1'b0; ifb.cpu_addr = 32'h300;
    @(negedge clk);
    chk("t5_a_ack0", ifa.cpu_ack, 1);
    chk("t5_b_ack", ifb.cpu_ack, 1);
    if (ifa.cpu_ack) wq.push_back('{a: 32'h400, d: 32'h1});
    @(posedge clk); #1;
    ifb.cpu_req = 1'b0;
    ifa.cpu_addr = 32'h401; ifa.cpu_wdata = 32'h2;
    @(negedge clk);
    chk("t5_a_ack1", ifa.cpu_ack, 1);
    @(posedge clk); #1;
    ifa.cpu_req = 1'b0;
    chk("t5_a_busy_queued", ifa.busy, 1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    wq.delete();
    @(negedge clk);
    chk_zero("t5", 1'b0);
    chk_zero("t5", 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    load(1'b1, 32'h300, PINS, 4);
    load(1'b0, 32'h300, PINS, 2);

    repeat (5) @(posedge clk);
    #1;
    chk("final_wq_empty", 64'(wq.size()), 0);
    chk("final_rq_empty", 64'(rq_a.size() + rq_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
